logic_op_pipe: RTL and testbench
================================

// Module: logic_op_pipe
// PURPOSE
//  Parametrised, pipelined successor to the standalone bitwise gates (and2/INV/NAND2/MUX2).
//  Selects one of 8 bitwise ops per transaction and registers the result through STAGES slices.
//  Valid/ready handshake on both sides; throughput 1 op/cycle; saturating completion counter.
//  Sits in the verilator gates testbench and serves as the generic logic slice for the datapath.
// PARAMETERS
//  WIDTH   64  operand/result width in bits (>=1)
//  STAGES  2   pipeline register slices between input and output (1..4)
//  CNT_W   32  width of the completed-transaction counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input transaction present
//  in_ready   out  1      block accepts input this cycle
//  in_op      in   3      op select (logic_op_e)
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  in3        in   WIDTH  operand C; only bit 0 is used, as the MUX2 select
//  out_valid  out  1      result present at output
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  result
//  out_op     out  3      op that produced out_data (travels with the data)
//  done_cnt   out  CNT_W  number of completed output handshakes, saturating
// BEHAVIOUR
//  - Ops: 0 AND a&b | 1 OR a|b | 2 XOR a^b | 3 NAND ~(a&b) | 4 NOR ~(a|b) | 5 XNOR ~(a^b)
//         6 INV ~a (in2/in3 ignored) | 7 MUX2 in3[0] ? b : a (whole word).
//  - Result is computed combinationally from the inputs and captured into slice 1 on accept.
//    Slices 2..STAGES pass data and op through unchanged.
//  - Accept: in_valid && in_ready. Output handshake: out_valid && out_ready.
//  - Slice k loads when it is empty, or when its content moves on in the same cycle.
//    in_ready = ~v[1] | adv[1], where adv[k] = v[k] & (k==STAGES ? out_ready : (~v[k+1] | adv[k+1])).
//    The ready path is combinational across slices; no bubbles; full occupancy is STAGES items.
//  - Latency: an op accepted at cycle N appears on out_valid at cycle N+STAGES if not stalled.
//  - Backpressure: while out_ready=0, out_valid, out_data and out_op hold stable (AXI-style).
//    Upstream slices keep filling until all are full; then in_ready=0.
//  - Full pipe with out_ready=1 and in_valid=1: accept and emit in the same cycle, occupancy unchanged.
//  - in_valid=0: empty bubbles propagate; out_data holds its last value while out_valid=0.
//  - done_cnt increments by 1 on each output handshake; holds at 2^CNT_W-1 (no wrap).
//  - Reset (rst=1 at posedge): all valid bits 0, data/op regs 0, done_cnt 0. Effects:
//    out_valid=0, out_data=0, out_op=0, in_ready=1 in the cycle after reset.
//    Reset mid-operation discards in-flight items silently.
//    Input presented while rst=1 is not accepted.
//  - No X propagation: unused operand bits never reach the result mux.
// STRUCTURE
//  - gates_pkg: typedef enum logic [2:0] logic_op_e {OP_AND..OP_MUX2};
//    function logic_op_f(op, a, b, sel) parametrised on WIDTH via a parameterised class/let.
//  - Sub-module pipe_slice #(W): one valid/ready register slice (v, data, adv logic).
//    Instantiated STAGES times in a generate loop with payload {op, data}.
//  - Top: op compute, slice chain, done_cnt register.
// TESTING
//  1. Reset, then AND in1=64'hF0F0_..., in2=64'hFF00_..., out_ready=1
//     -> after 2 cycles out_data=64'hF000_F000_F000_F000, out_op=0, done_cnt=1.
//  2. All 8 ops back-to-back, in1=64'hA5A5..A5, in2=64'h0F0F..0F, in3=1
//     -> 8 results on 8 consecutive cycles; MUX2 result=64'h0F0F..0F; INV result=64'h5A5A..5A.
//  3. out_ready=0 with 3 inputs offered (STAGES=2)
//     -> first 2 accepted, in_ready=0 afterwards, out_data stable.
//     Raise out_ready -> 3 results in order, no loss or duplicate.
//  4. Full pipe, out_ready=1, in_valid=1 continuous for 100 cycles
//     -> in_ready stays 1, done_cnt=100-STAGES+1 at cycle 100.
//  5. Assert rst with 2 items in flight
//     -> next cycle out_valid=0, done_cnt=0, in_ready=1; the dropped items never appear.
//  6. CNT_W=4: 20 handshakes -> done_cnt saturates at 15.
//     Also sweep WIDTH=1/64 and STAGES=1/4 against a C reference model.

Source files
------------

// File: rtl/logic_op_pipe_pkg.sv
// Shared op encoding and the single-bit op evaluator. It is applied per bit, so the
// same function works for any operand width.
package logic_op_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_INV  = 3'd6,
    OP_MUX2 = 3'd7
  } logic_op_e;

  localparam int OP_W = 3;

  function automatic logic logic_op_bit(logic_op_e op, logic a, logic b, logic sel);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_INV:  r = ~a;
      OP_MUX2: r = sel ? b : a;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_op_pipe_slice.sv
// One valid/ready register slice. It can take a new item in the same cycle its
// current item leaves, so a full chain still streams one item per cycle.
module logic_op_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  logic         v;
  logic [W-1:0] data;
  logic         adv;
  logic         load;

  assign adv      = v & dn_ready;
  assign up_ready = ~v | adv;
  assign load     = up_valid & up_ready;
  assign dn_valid = v;
  assign dn_data  = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      v    <= 1'b0;
      data <= '0;
    end else if (load) begin
      v    <= 1'b1;
      data <= up_data;
    end else if (adv) begin
      v    <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Pipelined bitwise op unit: the result is computed on input, then carried with its
// op through STAGES slices, and output handshakes are counted in a saturating counter.
module logic_op_pipe
  import logic_op_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int PW = WIDTH + OP_W;

  logic [WIDTH-1:0] result;
  logic             v_c [STAGES+1];
  logic             r_c [STAGES+1];
  logic [PW-1:0]    d_c [STAGES+1];

  always_comb begin
    result = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result[i] = logic_op_bit(logic_op_e'(in_op), in1[i], in2[i], in3[0]);
    end
  end

  // Only bit 0 of in3 is the mux select; the rest is deliberately dropped.
  generate
    if (WIDTH > 1) begin : g_in3_spare
      logic unused_in3;
      assign unused_in3 = ^in3[WIDTH-1:1];
    end
  endgenerate

  assign v_c[0]      = in_valid;
  assign in_ready    = r_c[0];
  assign d_c[0]      = {in_op, result};
  assign r_c[STAGES] = out_ready;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
      logic_op_pipe_slice #(.W(PW)) u_slice (
        .clk      (clk),
        .rst      (rst),
        .up_valid (v_c[k]),
        .up_ready (r_c[k]),
        .up_data  (d_c[k]),
        .dn_valid (v_c[k+1]),
        .dn_ready (r_c[k+1]),
        .dn_data  (d_c[k+1])
      );
    end
  endgenerate

  assign out_valid = v_c[STAGES];
  assign out_data  = d_c[STAGES][WIDTH-1:0];
  assign out_op    = d_c[STAGES][PW-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready && (done_cnt != {CNT_W{1'b1}})) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_op_pipe.sv
// Scoreboard bench: drivers push expected results, negedge monitors pop and compare.
// A second narrow instance (WIDTH=1, STAGES=4, CNT_W=4) covers counter saturation.
module tb_logic_op_pipe;
  import logic_op_pipe_pkg::*;

  localparam int W = 64;
  localparam int S = 2;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  op;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [2:0] in_op = 3'd0, out_op;
  logic [W-1:0] in1 = '0, in2 = '0, in3 = '0, out_data;
  logic [31:0] done_cnt;

  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [2:0] b_in_op = 3'd0, b_out_op;
  logic [0:0] b_in1 = '0, b_in2 = '0, b_in3 = '0, b_out_data;
  logic [3:0] b_done_cnt;

  logic_op_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in1(in1), .in2(in2), .in3(in3), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_op(out_op), .done_cnt(done_cnt)
  );

  logic_op_pipe #(.WIDTH(1), .STAGES(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_op(b_out_op), .done_cnt(b_done_cnt)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int tot = 0;
  exp_t q[$];
  exp_t q2[$];
  int hs_cyc[$];
  exp_t e_m, e_m2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [63:0] model(logic [2:0] op, logic [63:0] a, logic [63:0] b, logic s);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return ~(a ^ b);
      3'd6: return ~a;
      default: return s ? b : a;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got %h with nothing outstanding", out_data);
      end else begin
        e_m = q.pop_front();
        chk("out_data", out_data, e_m.data);
        chk("out_op", {61'd0, out_op}, {61'd0, e_m.op});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_out_valid && b_out_ready) begin
      if (q2.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output_b: got %h with nothing outstanding", b_out_data);
      end else begin
        e_m2 = q2.pop_front();
        chk("out_data_b", {63'd0, b_out_data}, {63'd0, e_m2.data[0]});
        chk("out_op_b", {61'd0, b_out_op}, {61'd0, e_m2.op});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] expv);
    in_valid = 1'b1; in_op = op; in1 = a; in2 = b; in3 = c;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{data: expv, op: op});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (q.size() == 0 && q2.size() == 0 && !out_valid && !b_out_valid) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] exp_ops [8];
    logic [63:0] hold, a, b, c, ev;
    logic ok;
    exp_ops[0] = {8{8'h05}}; exp_ops[1] = {8{8'hAF}};
    exp_ops[2] = {8{8'hAA}}; exp_ops[3] = {8{8'hFA}};
    exp_ops[4] = {8{8'h50}}; exp_ops[5] = {8{8'h55}};
    exp_ops[6] = {8{8'h5A}}; exp_ops[7] = {8{8'h0F}};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_out_op", {61'd0, out_op}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_done_cnt", {32'd0, done_cnt}, 64'd0);
    @(posedge clk); #1;

    // Single AND with fixed latency
    out_ready = 1'b1;
    send(3'd0, {4{16'hF0F0}}, {4{16'hFF00}}, 64'd0, 64'hF000_F000_F000_F000);
    @(negedge clk);
    chk("latency_stage1_empty_out", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    chk("and_done_cnt", {32'd0, done_cnt}, 64'd1);
    tot = 1;
    @(posedge clk); #1;

    // All eight ops back-to-back
    hs_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(3'(i), {8{8'hA5}}, {8{8'h0F}}, 64'd1, exp_ops[i]);
    wait_drain();
    tot += 8;
    chk("ops_count", hs_cyc.size(), 8);
    if (hs_cyc.size() == 8) chk("ops_consecutive", hs_cyc[7] - hs_cyc[0], 7);
    chk("ops_done_cnt", {32'd0, done_cnt}, tot);

    // Backpressure: fill, stall, release
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd2; in1 = 64'h1111; in2 = 64'h0101; in3 = '0;
    @(negedge clk);
    chk("bp_ready0", {63'd0, in_ready}, 64'd1);
    q.push_back('{data: 64'h1010, op: 3'd2});
    @(posedge clk); #1;
    in_op = 3'd1; in1 = 64'h2200; in2 = 64'h0033;
    @(negedge clk);
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    q.push_back('{data: 64'h2233, op: 3'd1});
    @(posedge clk); #1;
    in_op = 3'd7; in1 = 64'h4444; in2 = 64'h7777; in3 = 64'd1;
    @(negedge clk);
    chk("bp_full_not_ready", {63'd0, in_ready}, 64'd0);
    hold = out_data;
    chk("bp_head_data", hold, 64'h1010);
    ok = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (in_ready || !out_valid || out_data !== hold || out_op !== 3'd2) ok = 1'b0;
    end
    chk("bp_hold_stable", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    q.push_back('{data: 64'h7777, op: 3'd7});
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();
    tot += 3;
    chk("bp_done_cnt", {32'd0, done_cnt}, tot);

    // Continuous streaming for 100 cycles
    ok = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {32'd0, $urandom};
      ev = model(3'(k % 8), a, b, c[0]);
      in_valid = 1'b1; in_op = 3'(k % 8); in1 = a; in2 = b; in3 = c;
      @(negedge clk);
      if (!in_ready) ok = 1'b0;
      else q.push_back('{data: ev, op: 3'(k % 8)});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_in_ready_high", {63'd0, ok}, 64'd1);
    @(negedge clk);
    chk("stream_done_at_100", {32'd0, done_cnt}, tot + 100 - S);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stream_done_next", {32'd0, done_cnt}, tot + 100 - S + 1);
    @(posedge clk); #1;
    wait_drain();
    tot += 100;
    chk("stream_done_final", {32'd0, done_cnt}, tot);

    // Reset with two items in flight; input offered during reset is dropped too
    out_ready = 1'b0;
    send(3'd0, 64'hFF, 64'hF0, 64'd0, 64'hF0);
    send(3'd1, 64'h01, 64'h02, 64'd0, 64'h03);
    rst = 1'b1;
    in_valid = 1'b1; in_op = 3'd6; in1 = 64'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_done_cnt", {32'd0, done_cnt}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    ok = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b0;
    end
    chk("rst_no_ghosts", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;

    // Narrow instance: 20 handshakes saturate the 4-bit counter
    b_out_ready = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = 64'($urandom_range(0, 1)); b = 64'($urandom_range(0, 1)); c = 64'($urandom_range(0, 1));
      ev = model(3'(k % 8), a, b, c[0]);
      b_in_valid = 1'b1; b_in_op = 3'(k % 8); b_in1 = a[0]; b_in2 = b[0]; b_in3 = c[0];
      @(negedge clk);
      if (!b_in_ready) ok = 1'b0;
      else q2.push_back('{data: ev, op: 3'(k % 8)});
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    chk("narrow_in_ready_high", {63'd0, ok}, 64'd1);
    wait_drain();
    chk("narrow_done_saturated", {60'd0, b_done_cnt}, 64'd15);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
